flash_seq: RTL and testbench
============================

FLASH_SEQ -- requirements
Module: flash_seq

Interface
REQ-001 Parameter GAP, default 17, meaning CLK cycles from one byte-write strobe to the next; covers the 16-cycle byte shift plus one idle cycle.
REQ-002 Parameter CS_SETUP, default 2, meaning CLK cycles from FCS falling to the first byte-write strobe.
REQ-003 Parameter CS_HOLD, default 2, meaning CLK cycles from the end of the last byte to FCS rising.
REQ-004 CLK  input  1  system clock, 125 MHz.
REQ-005 RSTN  input  1  reset; one clock, synchronous, active-low.
REQ-006 START  input  1  one-cycle request to run a transaction; sampled only in IDLE.
REQ-007 CMD  input  8  flash command byte.
REQ-008 ADDR  input  24  flash address, sent MSB byte first.
REQ-009 WITH_ADDR  input  1  1 means the 3 address bytes follow CMD.
REQ-010 NBYTES  input  9  number of bytes to read after the header (0..511).
REQ-011 BUSY  output  1  high from the START acceptance cycle until DONE.
REQ-012 DONE  output  1  one-cycle pulse at transaction end.
REQ-013 DOUT  output  8  last byte read.
REQ-014 DVALID  output  1  one-cycle pulse when DOUT is updated.
REQ-015 FCS  output  1  flash chip select, active low.
REQ-016 MASTER  output  1  drives the byte engine ENABLE; equals BUSY.
REQ-017 BDATA_OUT  output  8  byte presented to the byte engine.
REQ-018 BWS  output  1  one-cycle byte-engine write strobe; BDATA_OUT is valid in the same cycle.
REQ-019 BRS  output  1  one-cycle byte-engine read strobe.
REQ-020 BDATA_IN  input  8  byte-engine shift-in register; valid only while BRS is high.

Function
REQ-021 The FSM states shall be IDLE, SETUP, SEND, WAIT, RDCAP, HOLD and FIN.
REQ-022 IDLE: on START=1, latch CMD, ADDR, WITH_ADDR and NBYTES; drive FCS=0 and BUSY=1; go to SETUP.
REQ-023 SETUP: count CS_SETUP cycles, then go to SEND.
REQ-024 SEND: for one cycle, assert BWS with the next header byte (CMD, then ADDR[23:16], ADDR[15:8], ADDR[7:0] if WITH_ADDR), or with 0xFF for each read byte; go to WAIT.
REQ-025 WAIT: the gap counter shall run so that consecutive BWS pulses are exactly GAP cycles apart.
- At expiry after a header byte with more to send, go to SEND.
- At expiry after a read byte, go to RDCAP.
- When no bytes remain, go to HOLD.
REQ-026 RDCAP: for one cycle, assert BRS and capture BDATA_IN into DOUT; pulse DVALID on the next cycle.
- If read bytes remain, go to SEND in the cycle after BRS, keeping GAP spacing measured from the previous BWS plus 1.
- Otherwise go to HOLD.
REQ-027 HOLD: count CS_HOLD cycles, then set FCS=1 and go to FIN.
REQ-028 FIN: pulse DONE, set BUSY=0 and MASTER=0 in the same cycle, and return to IDLE.
REQ-029 With NBYTES=0, no BRS shall occur; the transaction is header only.
REQ-030 START while BUSY=1 shall be ignored, and latched inputs shall not change.
REQ-031 The read-byte counter shall be 9 bits; with NBYTES=511, exactly 511 DVALID pulses shall occur, with no wrap-around.
REQ-032 BWS and BRS shall never be high in the same cycle; BRS shall never be high while FCS=1.
REQ-033 DOUT shall hold its value between DVALID pulses.

Reset
REQ-034 While RSTN=0 at a CLK edge, the block shall go to IDLE with these outputs:
- FCS=1, BUSY=0, MASTER=0, DONE=0, DVALID=0, BWS=0, BRS=0;
- DOUT=0x00, BDATA_OUT=0x00;
- all counters cleared.
REQ-035 Reset mid-transaction shall abort immediately with no DONE pulse; FCS shall rise in the first cycle reset is sampled.

Structure
REQ-036 The FSM state encoding and the flash command constants (READ=0x03, WREN=0x06, RDSR=0x05, PP=0x02) shall live in the shared package flash_pkg.
REQ-037 The GAP/CS_SETUP/CS_HOLD down-counter shall be a single sub-module, flash_tmr (load, count, zero flag); everything else is flat.

Verification
REQ-038 START, CMD=0x06, WITH_ADDR=0, NBYTES=0 -> FCS low; 1 BWS with 0x06; no BRS; DONE 2+17+2+1 cycles after acceptance; FCS high.
REQ-039 START, CMD=0x03, ADDR=0x123456, NBYTES=2, byte-engine model returns 0xA5, 0x5A -> BWS bytes 03,12,34,56,FF,FF each 17 cycles apart (first pair); DOUT=0xA5 then 0x5A with two DVALID pulses; one DONE.
REQ-040 Second START pulse 5 cycles after the first, during REQ-039 -> ignored; byte sequence identical; one DONE.
REQ-041 RSTN low for 1 cycle after the 3rd BWS of REQ-039 -> next cycle FCS=1, BUSY=0, no DONE, no further BWS; a new START then runs normally.
REQ-042 NBYTES=511, WITH_ADDR=1 -> exactly 515 BWS pulses, 511 BRS pulses and 511 DVALID pulses; BWS and BRS never coincident.

Source files
------------

// File: rtl/flash_pkg.sv
// ============================================================================
// flash_pkg : shared state encoding, flash command codes and header helper
// Revision  : 1.0 - initial release
// ============================================================================
`default_nettype none

package flash_pkg;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_SETUP = 3'd1,
    ST_SEND  = 3'd2,
    ST_WAIT  = 3'd3,
    ST_RDCAP = 3'd4,
    ST_HOLD  = 3'd5,
    ST_FIN   = 3'd6
  } state_t;

  localparam logic [7:0] c_cmd_read = 8'h03;
  localparam logic [7:0] c_cmd_wren = 8'h06;
  localparam logic [7:0] c_cmd_rdsr = 8'h05;
  localparam logic [7:0] c_cmd_pp   = 8'h02;

  localparam int c_tmr_w = 16;

  // Header byte order: command first, then address MSB byte first.
  function automatic logic [7:0] hdr_byte(input logic [2:0]  idx,
                                          input logic [7:0]  cmd,
                                          input logic [23:0] addr);
    logic [7:0] b;
    case (idx)
      3'd0:    b = cmd;
      3'd1:    b = addr[23:16];
      3'd2:    b = addr[15:8];
      default: b = addr[7:0];
    endcase
    return b;
  endfunction

endpackage

`default_nettype wire

// File: rtl/flash_seq_if.sv
// ============================================================================
// flash_seq_if : request/status and byte-engine signals of the flash sequencer
// Revision     : 1.0 - initial release
// ============================================================================
`default_nettype none

interface flash_seq_if;

  logic        i_start;
  logic [7:0]  i_cmd;
  logic [23:0] i_addr;
  logic        i_with_addr;
  logic [8:0]  i_nbytes;
  logic        o_busy;
  logic        o_done;
  logic [7:0]  o_dout;
  logic        o_dvalid;
  logic        o_fcs;
  logic        o_master;
  logic [7:0]  o_bdata_out;
  logic        o_bws;
  logic        o_brs;
  logic [7:0]  i_bdata_in;

  modport master (
    output i_start, i_cmd, i_addr, i_with_addr, i_nbytes, i_bdata_in,
    input  o_busy, o_done, o_dout, o_dvalid, o_fcs, o_master,
           o_bdata_out, o_bws, o_brs
  );

  modport slave (
    input  i_start, i_cmd, i_addr, i_with_addr, i_nbytes, i_bdata_in,
    output o_busy, o_done, o_dout, o_dvalid, o_fcs, o_master,
           o_bdata_out, o_bws, o_brs
  );

endinterface

`default_nettype wire

// File: rtl/flash_tmr.sv
// ============================================================================
// flash_tmr : loadable down-counter with zero flag for setup/gap/hold timing
// Revision  : 1.0 - initial release
// ============================================================================
`default_nettype none

module flash_tmr #(
  parameter int WIDTH = 16
) (
  input  wire logic             i_clk,
  input  wire logic             i_rstn,
  input  wire logic             i_load,
  input  wire logic [WIDTH-1:0] i_val,
  input  wire logic             i_count,
  output logic                  o_zero
);

  logic [WIDTH-1:0] r_cnt;

  always_ff @(posedge i_clk) begin
    if (!i_rstn) begin
      r_cnt <= '0;
    end else if (i_load) begin
      r_cnt <= i_val;
    end else if (i_count && (r_cnt != '0)) begin
      r_cnt <= r_cnt - 1'b1;
    end
  end

  assign o_zero = (r_cnt == '0);

endmodule

`default_nettype wire

// File: rtl/flash_seq.sv
// ============================================================================
// flash_seq : SPI flash transaction sequencer driving an external byte engine
// Revision  : 1.0 - initial release
// ============================================================================
`default_nettype none

module flash_seq
  import flash_pkg::*;
#(
  parameter int GAP      = 17,
  parameter int CS_SETUP = 2,
  parameter int CS_HOLD  = 2
) (
  input  wire logic  i_clk,
  input  wire logic  i_rstn,
  flash_seq_if.slave bus
);

  // A timed state lasts (load value + 1) cycles.
  localparam logic [c_tmr_w-1:0] c_ld_setup = c_tmr_w'(CS_SETUP - 1);
  localparam logic [c_tmr_w-1:0] c_ld_gap   = c_tmr_w'(GAP - 2);
  localparam logic [c_tmr_w-1:0] c_ld_hold  = c_tmr_w'(CS_HOLD - 1);
  localparam logic [c_tmr_w-1:0] c_ld_holdw = c_tmr_w'(CS_HOLD);

  state_t              r_state;
  state_t              w_next;
  logic                w_ld;
  logic [c_tmr_w-1:0]  w_ld_val;
  logic                w_tmr_run;
  logic                w_zero;

  logic [7:0]          r_cmd;
  logic [23:0]         r_addr;
  logic                r_with_addr;
  logic [8:0]          r_rd_cnt;
  logic [2:0]          r_hdr_idx;
  logic                r_last_rd;
  logic [7:0]          r_dout;
  logic                r_dvalid;

  logic [2:0]          w_nhdr;
  logic                w_hdr_left;
  logic                w_rd_left;

  assign w_nhdr     = r_with_addr ? 3'd4 : 3'd1;
  assign w_hdr_left = (r_hdr_idx < w_nhdr);
  assign w_rd_left  = (r_rd_cnt != 9'd0);
  assign w_tmr_run  = (r_state == ST_SETUP) || (r_state == ST_WAIT) ||
                      (r_state == ST_HOLD);

  flash_tmr #(
    .WIDTH (c_tmr_w)
  ) u_tmr (
    .i_clk   (i_clk),
    .i_rstn  (i_rstn),
    .i_load  (w_ld),
    .i_val   (w_ld_val),
    .i_count (w_tmr_run),
    .o_zero  (w_zero)
  );

  always_ff @(posedge i_clk) begin
    if (!i_rstn) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  always_comb begin
    w_next   = r_state;
    w_ld     = 1'b0;
    w_ld_val = '0;
    case (r_state)
      ST_IDLE: begin
        if (bus.i_start) begin
          w_next   = ST_SETUP;
          w_ld     = 1'b1;
          w_ld_val = c_ld_setup;
        end
      end
      ST_SETUP: begin
        if (w_zero) w_next = ST_SEND;
      end
      ST_SEND: begin
        w_next   = ST_WAIT;
        w_ld     = 1'b1;
        w_ld_val = c_ld_gap;
      end
      ST_WAIT: begin
        if (w_zero) begin
          if (r_last_rd) begin
            w_next = ST_RDCAP;
          end else if (w_hdr_left || w_rd_left) begin
            w_next = ST_SEND;
          end else begin
            // Hold also covers the idle cycle that ends the last header byte.
            w_next   = ST_HOLD;
            w_ld     = 1'b1;
            w_ld_val = c_ld_holdw;
          end
        end
      end
      ST_RDCAP: begin
        if (w_rd_left) begin
          w_next = ST_SEND;
        end else begin
          w_next   = ST_HOLD;
          w_ld     = 1'b1;
          w_ld_val = c_ld_hold;
        end
      end
      ST_HOLD: begin
        if (w_zero) w_next = ST_FIN;
      end
      ST_FIN: begin
        w_next = ST_IDLE;
      end
      default: begin
        w_next = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge i_clk) begin
    if (!i_rstn) begin
      r_cmd       <= 8'h00;
      r_addr      <= 24'h000000;
      r_with_addr <= 1'b0;
      r_rd_cnt    <= 9'd0;
      r_hdr_idx   <= 3'd0;
      r_last_rd   <= 1'b0;
      r_dout      <= 8'h00;
      r_dvalid    <= 1'b0;
    end else begin
      r_dvalid <= (r_state == ST_RDCAP);
      case (r_state)
        ST_IDLE: begin
          if (bus.i_start) begin
            r_cmd       <= bus.i_cmd;
            r_addr      <= bus.i_addr;
            r_with_addr <= bus.i_with_addr;
            r_rd_cnt    <= bus.i_nbytes;
            r_hdr_idx   <= 3'd0;
            r_last_rd   <= 1'b0;
          end
        end
        ST_SEND: begin
          if (w_hdr_left) begin
            r_hdr_idx <= r_hdr_idx + 3'd1;
            r_last_rd <= 1'b0;
          end else begin
            r_rd_cnt  <= r_rd_cnt - 9'd1;
            r_last_rd <= 1'b1;
          end
        end
        ST_RDCAP: begin
          r_dout <= bus.i_bdata_in;
        end
        default: begin
        end
      endcase
    end
  end

  assign bus.o_busy      = (r_state != ST_IDLE) && (r_state != ST_FIN);
  assign bus.o_master    = bus.o_busy;
  assign bus.o_fcs       = (r_state == ST_IDLE) || (r_state == ST_FIN);
  assign bus.o_done      = (r_state == ST_FIN);
  assign bus.o_bws       = (r_state == ST_SEND);
  assign bus.o_brs       = (r_state == ST_RDCAP);
  assign bus.o_bdata_out = (r_state != ST_SEND) ? 8'h00 :
                           w_hdr_left ? hdr_byte(r_hdr_idx, r_cmd, r_addr) :
                           8'hFF;
  assign bus.o_dout      = r_dout;
  assign bus.o_dvalid    = r_dvalid;

endmodule

`default_nettype wire

// File: tb/tb_flash_seq.sv
// ============================================================================
// tb_flash_seq : directed self-checking bench for flash_seq
// Revision     : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_flash_seq;
  import flash_pkg::*;

  logic clk  = 1'b0;
  logic rstn = 1'b0;
  always #4 clk = ~clk;

  flash_seq_if u_if ();

  flash_seq #(
    .GAP      (17),
    .CS_SETUP (2),
    .CS_HOLD  (2)
  ) u_dut (
    .i_clk  (clk),
    .i_rstn (rstn),
    .bus    (u_if)
  );

  int n_checks = 0;
  int n_fail   = 0;

  int cyc = 0, bws_cnt = 0, brs_cnt = 0, dv_cnt = 0, done_cnt = 0;
  int coinc_cnt = 0, brs_fcs_cnt = 0, rise_cyc = 0, done_cyc = 0;
  logic prev_busy = 1'b0;
  logic [7:0] bws_byte [$];
  int         bws_cyc  [$];
  logic [7:0] dv_byte  [$];

  // Byte-engine return data, indexed by global read-strobe count.
  function automatic logic [7:0] pat(input int k);
    if (k == 0) return 8'hA5;
    if (k == 1) return 8'h5A;
    return 8'(k * 3 + 1);
  endfunction

  always @(negedge clk) begin
    cyc++;
    if (u_if.o_bws) begin
      bws_cnt++;
      bws_byte.push_back(u_if.o_bdata_out);
      bws_cyc.push_back(cyc);
    end
    if (u_if.o_brs) begin
      u_if.i_bdata_in = pat(brs_cnt);
      brs_cnt++;
    end
    if (u_if.o_brs && u_if.o_bws) coinc_cnt++;
    if (u_if.o_brs && u_if.o_fcs) brs_fcs_cnt++;
    if (u_if.o_dvalid) begin
      dv_cnt++;
      dv_byte.push_back(u_if.o_dout);
    end
    if (u_if.o_done) begin
      done_cnt++;
      done_cyc = cyc;
    end
    if (u_if.o_busy && !prev_busy) rise_cyc = cyc;
    prev_busy = u_if.o_busy;
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(negedge clk);
    #1;
  endtask

  task automatic start_txn(input logic [7:0] cmd, input logic [23:0] addr,
                           input logic wa, input logic [8:0] nb);
    u_if.i_cmd       = cmd;
    u_if.i_addr      = addr;
    u_if.i_with_addr = wa;
    u_if.i_nbytes    = nb;
    u_if.i_start     = 1'b1;
    tick();
    u_if.i_start     = 1'b0;
  endtask

  task automatic wait_done(input int snap, input int budget, input string tag);
    int n = 0;
    while (done_cnt == snap && n < budget) begin
      tick();
      n++;
    end
    check(tag, 32'(done_cnt != snap), 32'd1);
  endtask

  initial begin
    int b, r, v, d, c0, f0, n;
    logic [7:0] exp_hdr [6];
    u_if.i_start     = 1'b0;
    u_if.i_cmd       = 8'h00;
    u_if.i_addr      = 24'h0;
    u_if.i_with_addr = 1'b0;
    u_if.i_nbytes    = 9'd0;
    u_if.i_bdata_in  = 8'h00;

    rstn = 1'b0;
    repeat (3) tick();
    check("rst_fcs",    32'(u_if.o_fcs),       32'd1);
    check("rst_busy",   32'(u_if.o_busy),      32'd0);
    check("rst_master", 32'(u_if.o_master),    32'd0);
    check("rst_done",   32'(u_if.o_done),      32'd0);
    check("rst_dvalid", 32'(u_if.o_dvalid),    32'd0);
    check("rst_bws",    32'(u_if.o_bws),       32'd0);
    check("rst_brs",    32'(u_if.o_brs),       32'd0);
    check("rst_dout",   32'(u_if.o_dout),      32'h00);
    check("rst_bdata",  32'(u_if.o_bdata_out), 32'h00);
    rstn = 1'b1;
    tick();

    // Header-only WREN.
    b = bws_cnt; r = brs_cnt; d = done_cnt;
    start_txn(c_cmd_wren, 24'h0, 1'b0, 9'd0);
    check("wren_fcs_low", 32'(u_if.o_fcs),    32'd0);
    check("wren_busy",    32'(u_if.o_busy),   32'd1);
    check("wren_master",  32'(u_if.o_master), 32'd1);
    wait_done(d, 100, "wren_done_timeout");
    repeat (2) tick();
    check("wren_bws_cnt",   32'(bws_cnt - b),         32'd1);
    check("wren_bws_byte",  32'(bws_byte[b]),         32'h06);
    check("wren_brs_cnt",   32'(brs_cnt - r),         32'd0);
    check("wren_done_cnt",  32'(done_cnt - d),        32'd1);
    check("wren_done_lat",  32'(done_cyc - rise_cyc), 32'd22);
    check("wren_bws_lat",   32'(bws_cyc[b] - rise_cyc), 32'd2);
    check("wren_fcs_high",  32'(u_if.o_fcs),          32'd1);
    check("wren_busy_low",  32'(u_if.o_busy),         32'd0);

    // READ of 2 bytes, with a second START 5 cycles in that must be ignored.
    b = bws_cnt; r = brs_cnt; v = dv_cnt; d = done_cnt;
    start_txn(c_cmd_read, 24'h123456, 1'b1, 9'd2);
    repeat (4) tick();
    start_txn(c_cmd_wren, 24'h000000, 1'b0, 9'd0);
    wait_done(d, 400, "read2_done_timeout");
    repeat (3) tick();
    exp_hdr = '{8'h03, 8'h12, 8'h34, 8'h56, 8'hFF, 8'hFF};
    check("read2_bws_cnt", 32'(bws_cnt - b), 32'd6);
    for (int i = 0; i < 6; i++)
      check($sformatf("read2_byte%0d", i), 32'(bws_byte[b + i]), 32'(exp_hdr[i]));
    for (int i = 0; i < 5; i++)
      check($sformatf("read2_gap%0d", i), 32'(bws_cyc[b + i + 1] - bws_cyc[b + i]),
            (i < 4) ? 32'd17 : 32'd18);
    check("read2_brs_cnt", 32'(brs_cnt - r),  32'd2);
    check("read2_dv_cnt",  32'(dv_cnt - v),   32'd2);
    check("read2_dv0",     32'(dv_byte[v]),   32'hA5);
    check("read2_dv1",     32'(dv_byte[v+1]), 32'h5A);
    check("read2_done",    32'(done_cnt - d), 32'd1);
    repeat (5) tick();
    check("read2_dout_hold", 32'(u_if.o_dout), 32'h5A);
    check("read2_busy_low",  32'(u_if.o_busy), 32'd0);

    // Reset after the third byte strobe aborts the transaction.
    b = bws_cnt; d = done_cnt;
    start_txn(c_cmd_read, 24'h123456, 1'b1, 9'd2);
    n = 0;
    while ((bws_cnt - b) < 3 && n < 200) begin
      tick();
      n++;
    end
    check("abort_third_bws", 32'(bws_cnt - b), 32'd3);
    rstn = 1'b0;
    tick();
    check("abort_fcs",  32'(u_if.o_fcs),  32'd1);
    check("abort_busy", 32'(u_if.o_busy), 32'd0);
    check("abort_bws",  32'(u_if.o_bws),  32'd0);
    rstn = 1'b1;
    repeat (40) tick();
    check("abort_no_more_bws", 32'(bws_cnt - b),  32'd3);
    check("abort_no_done",     32'(done_cnt - d), 32'd0);

    b = bws_cnt; r = brs_cnt; v = dv_cnt; d = done_cnt;
    start_txn(c_cmd_read, 24'hABCDEF, 1'b1, 9'd1);
    wait_done(d, 300, "post_rst_done_timeout");
    repeat (2) tick();
    exp_hdr = '{8'h03, 8'hAB, 8'hCD, 8'hEF, 8'hFF, 8'h00};
    check("post_rst_bws_cnt", 32'(bws_cnt - b), 32'd5);
    for (int i = 0; i < 5; i++)
      check($sformatf("post_rst_byte%0d", i), 32'(bws_byte[b + i]), 32'(exp_hdr[i]));
    check("post_rst_dv_cnt", 32'(dv_cnt - v),   32'd1);
    check("post_rst_dv0",    32'(dv_byte[v]),   32'(pat(r)));
    check("post_rst_done",   32'(done_cnt - d), 32'd1);

    // Maximum read length.
    b = bws_cnt; r = brs_cnt; v = dv_cnt; d = done_cnt;
    c0 = coinc_cnt; f0 = brs_fcs_cnt;
    start_txn(c_cmd_read, 24'h000100, 1'b1, 9'd511);
    wait_done(d, 12000, "max_done_timeout");
    repeat (2) tick();
    check("max_bws_cnt",  32'(bws_cnt - b),       32'd515);
    check("max_brs_cnt",  32'(brs_cnt - r),       32'd511);
    check("max_dv_cnt",   32'(dv_cnt - v),        32'd511);
    check("max_dout",     32'(u_if.o_dout),       32'(pat(r + 510)));
    check("max_coinc",    32'(coinc_cnt - c0),    32'd0);
    check("max_brs_fcs",  32'(brs_fcs_cnt - f0),  32'd0);
    check("max_done",     32'(done_cnt - d),      32'd1);
    check("all_coinc",    32'(coinc_cnt),         32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

`default_nettype wire
